// File: rtl/hilo_div_ctrl_if.sv
// rtl/hilo_div_ctrl_if.sv - execute-stage side of the HI/LO controller
//
// Groups the issue handshake and the architectural HI/LO read-out.
//   op_valid, op, rs, rt : operation presented by the execute stage
//   stall, busy          : hold the issuing stage / long operation outstanding
//   hi, lo               : architectural HI/LO registers
// master : execute stage (drives the operation)
// slave  : hilo_div_ctrl
interface hilo_div_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, op, rs, rt,
        input  stall, busy, hi, lo
    );

    modport slave (
        input  op_valid, op, rs, rt,
        output stall, busy, hi, lo
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// rtl/hilo_div_ctrl.sv - HI/LO issue and write-back controller for DIV/DIVU/MTHI/MTLO
//
// Accepts operations from the execute stage while idle, drives an external
// iterative unsigned divider with operand magnitudes, sign-corrects its result
// and writes quotient to LO and remainder to HI. Divide by zero never starts
// the divider: HI takes the dividend and LO becomes all ones.
//
// Optional feature macro: HILO_MULT_EN
//   defined   : MULT/MULTU run an internal radix-2 shift-add multiplier
//   undefined : MULT/MULTU behave as NOP
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   ex           execute-stage interface (slave modport)
//   div_dividend dividend magnitude to the divider core (registered)
//   div_divisor  divisor magnitude to the divider core (registered)
//   div_start    one-cycle start pulse to the divider core
//   div_q, div_r divider quotient / remainder, valid once div_busy drops
//   div_busy     divider busy, rises on the edge that samples div_start
module hilo_div_ctrl (
    input  logic              clock,
    input  logic              reset,
    hilo_div_ctrl_if.slave    ex,
    output logic [31:0]       div_dividend,
    output logic [31:0]       div_divisor,
    output logic              div_start,
    input  logic [31:0]       div_q,
    input  logic [31:0]       div_r,
    input  logic              div_busy
);

    localparam logic [2:0] OP_DIV   = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_MULTU = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        MUL   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

`ifdef HILO_MULT_EN
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] prod_q, prod_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_prod_q, neg_prod_d;
    logic [63:0] prod_fix;
`endif

    logic        is_signed;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    assign is_signed = (ex.op == OP_DIV) || (ex.op == OP_MULT);

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
`ifdef HILO_MULT_EN
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        neg_prod_d = neg_prod_q;
        prod_fix   = neg_prod_q ? (~prod_q + 64'd1) : prod_q;
`endif

        case (state_q)
            IDLE: begin
                if (ex.op_valid) begin
                    case (ex.op)
                        OP_DIV, OP_DIVU: begin
                            if (ex.rt == 32'd0) begin
                                hi_d = ex.rs;
                                lo_d = 32'hFFFF_FFFF;
                            end else begin
                                neg_quo_d  = is_signed & (ex.rs[31] ^ ex.rt[31]);
                                neg_rem_d  = is_signed & ex.rs[31];
                                dividend_d = mag(ex.rs, is_signed);
                                divisor_d  = mag(ex.rt, is_signed);
                                state_d    = START;
                            end
                        end
`ifdef HILO_MULT_EN
                        OP_MULT, OP_MULTU: begin
                            neg_prod_d = is_signed & (ex.rs[31] ^ ex.rt[31]);
                            mcand_d    = {32'd0, mag(ex.rs, is_signed)};
                            mplier_d   = mag(ex.rt, is_signed);
                            prod_d     = 64'd0;
                            cnt_d      = 6'd0;
                            state_d    = MUL;
                        end
`endif
                        OP_MTHI: hi_d = ex.rs;
                        OP_MTLO: lo_d = ex.rs;
                        default: ;
                    endcase
                end
            end

            START: state_d = WAIT;

            WAIT: begin
                if (!div_busy) begin
                    lo_d    = neg_quo_q ? (~div_q + 32'd1) : div_q;
                    hi_d    = neg_rem_q ? (~div_r + 32'd1) : div_r;
                    state_d = IDLE;
                end
            end

`ifdef HILO_MULT_EN
            MUL: begin
                // 32 shift-add steps, then one write-back edge.
                if (cnt_q == 6'd32) begin
                    hi_d    = prod_fix[63:32];
                    lo_d    = prod_fix[31:0];
                    state_d = IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 6'd1;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

`ifdef HILO_MULT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand_q    <= 64'd0;
            mplier_q   <= 32'd0;
            prod_q     <= 64'd0;
            cnt_q      <= 6'd0;
            neg_prod_q <= 1'b0;
        end else begin
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            prod_q     <= prod_d;
            cnt_q      <= cnt_d;
            neg_prod_q <= neg_prod_d;
        end
    end
`endif

    assign ex.busy      = (state_q != IDLE);
    assign ex.stall     = ex.op_valid && (state_q != IDLE);
    assign ex.hi        = hi_q;
    assign ex.lo        = lo_q;
    assign div_start    = (state_q == START);
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

endmodule
